// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 2-flop line synchronizer, mid-bit sampling FSM,
// optional even/odd parity, 1 or 2 stop bits, one-cycle completion pulse.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int unsigned CLK_CY_PER_BIT = 87,
    parameter int unsigned DATA_BITS      = 8,
    parameter int unsigned PARITY_MODE    = 1,
    parameter int unsigned STOP_BITS      = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_Rx_Serial,
    output logic [DATA_BITS-1:0] o_Rx_Byte,
    output logic                 o_Rx_Dv,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err,
    output logic                 o_Busy
);

    localparam int unsigned CNT_W = $clog2(CLK_CY_PER_BIT);
    localparam int unsigned BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_CY_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'((CLK_CY_PER_BIT - 1) / 2);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    logic                 rx_meta, rx_sync;
    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic                 stop_q, stop_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic                 par_err_q, par_err_d;
    logic                 ferr_acc_q, ferr_acc_d;
    logic [DATA_BITS-1:0] byte_d;
    logic                 dv_d, perr_d, ferr_d, busy_d;
    logic                 cnt_last, stop_fail;

    // Line synchronizer, idles high so reset never looks like a start bit
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Serial;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            stop_q       <= 1'b0;
            shreg_q      <= '0;
            par_err_q    <= 1'b0;
            ferr_acc_q   <= 1'b0;
            o_Rx_Byte    <= '0;
            o_Rx_Dv      <= 1'b0;
            o_Parity_Err <= 1'b0;
            o_Frame_Err  <= 1'b0;
            o_Busy       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            stop_q       <= stop_d;
            shreg_q      <= shreg_d;
            par_err_q    <= par_err_d;
            ferr_acc_q   <= ferr_acc_d;
            o_Rx_Byte    <= byte_d;
            o_Rx_Dv      <= dv_d;
            o_Parity_Err <= perr_d;
            o_Frame_Err  <= ferr_d;
            o_Busy       <= busy_d;
        end
    end

    // Next-state and output decode; counter reloads to 0 at every sample point
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_d      = bit_q;
        stop_d     = stop_q;
        shreg_d    = shreg_q;
        par_err_d  = par_err_q;
        ferr_acc_d = ferr_acc_q;
        byte_d     = o_Rx_Byte;
        dv_d       = 1'b0;
        perr_d     = 1'b0;
        ferr_d     = 1'b0;
        cnt_last   = (cnt_q == CNT_LAST);
        stop_fail  = ferr_acc_q | ~rx_sync;

        case (state_q)
            S_IDLE: begin
                if (!rx_sync) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_sync) begin
                        state_d    = S_DATA;
                        bit_d      = '0;
                        par_err_d  = 1'b0;
                        ferr_acc_d = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DATA: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    shreg_d = {rx_sync, shreg_q[DATA_BITS-1:1]};
                    if (bit_q == BIT_LAST) begin
                        state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    par_err_d = (PARITY_MODE == 2) ? ~(^shreg_q ^ rx_sync)
                                                   :  (^shreg_q ^ rx_sync);
                    state_d   = S_STOP;
                    stop_d    = 1'b0;
                end
            end
            S_STOP: begin
                cnt_d = cnt_last ? '0 : cnt_q + CNT_W'(1);
                if (cnt_last) begin
                    if (stop_q == STOP_LAST) begin
                        byte_d  = shreg_q;
                        dv_d    = 1'b1;
                        perr_d  = (PARITY_MODE != 0) && par_err_q;
                        ferr_d  = stop_fail;
                        state_d = stop_fail ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        ferr_acc_d = stop_fail;
                        stop_d     = 1'b1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (rx_sync) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed scenarios plus random frames on a default
// instance (8E1) and a 7O2 instance, checked against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int unsigned BIT = 87;

    typedef struct packed {
        logic [8:0] b;
        logic       pe;
        logic       fe;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [7:0] byte0;
    logic       dv0, pe0, fe0, busy0;
    logic [6:0] byte1;
    logic       dv1, pe1, fe1, busy1;

    int         checks = 0;
    int         errors = 0;
    int         hold_viol = 0;
    int         stray = 0;
    logic [7:0] prev0 = '0;
    logic [6:0] prev1 = '0;
    ev_t        q0[$];
    ev_t        q1[$];

    always #50 clk = ~clk;

    uart_rx_cfg #(.CLK_CY_PER_BIT(BIT), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_Rx_Serial(rx0),
        .o_Rx_Byte(byte0), .o_Rx_Dv(dv0), .o_Parity_Err(pe0),
        .o_Frame_Err(fe0), .o_Busy(busy0)
    );

    uart_rx_cfg #(.CLK_CY_PER_BIT(BIT), .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(2)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_Rx_Serial(rx1),
        .o_Rx_Byte(byte1), .o_Rx_Dv(dv1), .o_Parity_Err(pe1),
        .o_Frame_Err(fe1), .o_Busy(busy1)
    );

    // Record every completion pulse; flag word changes or error flags outside a pulse
    always @(negedge clk) begin
        if (dv0) q0.push_back({1'b0, byte0, pe0, fe0});
        if (dv1) q1.push_back({2'b0, byte1, pe1, fe1});
        if (rst_n && !dv0 && (byte0 !== prev0)) hold_viol <= hold_viol + 1;
        if (rst_n && !dv1 && (byte1 !== prev1)) hold_viol <= hold_viol + 1;
        if (((pe0 | fe0) && !dv0) || ((pe1 | fe1) && !dv1)) stray <= stray + 1;
        prev0 <= byte0;
        prev1 <= byte1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx0 = v;
        else            rx1 = v;
    endtask

    // Start bit, data LSB first, optional parity, stop bits; line left at last stop value
    task automatic send_frame(input int which, input logic [8:0] d, input int nbits,
                              input logic use_p, input logic p,
                              input logic [1:0] stp, input int nstop);
        drive(which, 1'b0);
        wait_cycles(BIT);
        for (int i = 0; i < nbits; i++) begin
            drive(which, d[i]);
            wait_cycles(BIT);
        end
        if (use_p) begin
            drive(which, p);
            wait_cycles(BIT);
        end
        for (int i = 0; i < nstop; i++) begin
            drive(which, stp[i]);
            wait_cycles(BIT);
        end
    endtask

    task automatic go_idle(input int which, input int n);
        drive(which, 1'b1);
        wait_cycles(n);
    endtask

    function automatic logic model_perr(input logic [8:0] d, input int nbits,
                                        input logic p, input int mode);
        int ones = int'(p);
        for (int i = 0; i < nbits; i++) ones += int'(d[i]);
        if (mode == 2) return 1'(ones % 2 == 0);
        return 1'(ones % 2 == 1);
    endfunction

    function automatic logic model_ferr(input logic [1:0] stp, input int nstop);
        for (int i = 0; i < nstop; i++)
            if (stp[i] == 1'b0) return 1'b1;
        return 1'b0;
    endfunction

    // Exactly one completion event must be pending; compare it and drain the queue
    task automatic expect_frame(input int which, input string tag,
                                input logic [8:0] b, input logic pe, input logic fe);
        ev_t e;
        int  sz;
        e = '0;
        if (which == 0) begin
            sz = q0.size();
            if (sz > 0) e = q0.pop_front();
            q0.delete();
        end else begin
            sz = q1.size();
            if (sz > 0) e = q1.pop_front();
            q1.delete();
        end
        check({tag, "_dv_count"}, sz, 1);
        if (sz > 0) begin
            check({tag, "_byte"}, e.b, b);
            check({tag, "_perr"}, e.pe, pe);
            check({tag, "_ferr"}, e.fe, fe);
        end
    endtask

    initial begin
        // Reset state
        wait_cycles(5);
        check("rst_byte0", byte0, 0);
        check("rst_flags0", {dv0, pe0, fe0, busy0}, 0);
        check("rst_byte1", byte1, 0);
        check("rst_flags1", {dv1, pe1, fe1, busy1}, 0);
        rst_n = 1'b1;
        wait_cycles(20);

        // Clean 8'h8B, even parity bit 0
        send_frame(0, 9'h08B, 8, 1'b1, 1'b0, 2'b11, 1);
        go_idle(0, 20);
        expect_frame(0, "clean_8B", 9'h08B, 1'b0, 1'b0);
        check("busy_after_8B", busy0, 0);

        // Same word, wrong parity bit
        send_frame(0, 9'h08B, 8, 1'b1, 1'b1, 2'b11, 1);
        go_idle(0, 20);
        expect_frame(0, "perr_8B", 9'h08B, 1'b1, 1'b0);

        // Frame error with line held low afterwards, then a clean frame
        send_frame(0, 9'h03C, 8, 1'b1, 1'b0, 2'b10, 1);
        wait_cycles(3 * BIT);
        check("ferr_single_dv", q0.size(), 1);
        check("ferr_busy_while_low", busy0, 1);
        go_idle(0, 20);
        check("ferr_no_dv_on_rise", q0.size(), 1);
        expect_frame(0, "ferr_3C", 9'h03C, 1'b0, 1'b1);
        send_frame(0, 9'h0A5, 8, 1'b1, 1'b0, 2'b11, 1);
        go_idle(0, 20);
        expect_frame(0, "after_ferr_A5", 9'h0A5, 1'b0, 1'b0);

        // 20-cycle low glitch on an idle line
        drive(0, 1'b0);
        wait_cycles(10);
        check("glitch_busy_early", busy0, 1);
        wait_cycles(10);
        drive(0, 1'b1);
        wait_cycles(10);
        check("glitch_busy_until_sample", busy0, 1);
        wait_cycles(50);
        check("glitch_busy_released", busy0, 0);
        check("glitch_no_dv", q0.size(), 0);

        // Reset pulse during data bit 4 of 8'h8B
        drive(0, 1'b0);
        wait_cycles(BIT);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'(8'h8B >> i));
            wait_cycles(BIT);
        end
        drive(0, 1'b0);
        wait_cycles(40);
        check("midframe_busy", busy0, 1);
        rst_n = 1'b0;
        drive(0, 1'b1);
        wait_cycles(2);
        check("midrst_byte0", byte0, 0);
        check("midrst_flags0", {dv0, pe0, fe0, busy0}, 0);
        rst_n = 1'b1;
        wait_cycles(3 * BIT);
        check("midrst_no_dv", q0.size(), 0);
        send_frame(0, 9'h08B, 8, 1'b1, 1'b0, 2'b11, 1);
        go_idle(0, 20);
        expect_frame(0, "post_rst_8B", 9'h08B, 1'b0, 1'b0);

        // 7O2 instance: 7'h55, parity 1, second stop bit low
        send_frame(1, 9'h055, 7, 1'b1, 1'b1, 2'b01, 2);
        go_idle(1, 20);
        expect_frame(1, "cfg7o2_55", 9'h055, 1'b0, 1'b1);
        check("cfg7o2_busy_after", busy1, 0);

        // Random frames on both instances against the frame model
        for (int n = 0; n < 12; n++) begin
            logic [8:0] d;
            logic       p;
            logic [1:0] stp;
            d   = 9'($urandom_range(0, 255));
            p   = 1'($urandom_range(0, 1));
            stp = {1'b1, 1'($urandom_range(0, 3) != 0)};
            send_frame(0, d, 8, 1'b1, p, stp, 1);
            go_idle(0, 5 + int'($urandom_range(0, 25)));
            expect_frame(0, "rand8e1", d, model_perr(d, 8, p, 1), model_ferr(stp, 1));
        end
        for (int n = 0; n < 5; n++) begin
            logic [8:0] d;
            logic       p;
            logic [1:0] stp;
            d   = 9'($urandom_range(0, 127));
            p   = 1'($urandom_range(0, 1));
            stp = 2'($urandom_range(0, 3));
            send_frame(1, d, 7, 1'b1, p, stp, 2);
            go_idle(1, 5 + int'($urandom_range(0, 25)));
            expect_frame(1, "rand7o2", d, model_perr(d, 7, p, 2), model_ferr(stp, 2));
        end

        wait_cycles(10);
        check("byte_hold_between_dv", hold_viol, 0);
        check("no_flags_without_dv", stray, 0);
        check("final_q0_empty", q0.size(), 0);
        check("final_q1_empty", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 SHALL have parameter CLK_CY_PER_BIT, default 87, meaning i_clk cycles per serial bit (valid range 8..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (5..9).
REQ-003 SHALL have parameter PARITY_MODE, default 1, meaning 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bits checked per frame (1 or 2).
REQ-005 SHALL have port i_clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-006 SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial line, idle high.
REQ-008 SHALL have port o_Rx_Byte, output, DATA_BITS bits: last received data word.
REQ-009 SHALL have port o_Rx_Dv, output, 1 bit: one-cycle pulse marking frame complete.
REQ-010 SHALL have port o_Parity_Err, output, 1 bit: parity mismatch for the frame flagged by o_Rx_Dv.
REQ-011 SHALL have port o_Frame_Err, output, 1 bit: a stop bit was sampled low in the frame flagged by o_Rx_Dv.
REQ-012 SHALL have port o_Busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL pass i_Rx_Serial through a 2-flop synchronizer (reset value 1); all logic uses the synchronized bit.
REQ-014 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-015 In IDLE, a synchronized low SHALL move the FSM to START and clear the cycle counter.
REQ-016 START SHALL sample at count (CLK_CY_PER_BIT-1)/2: low -> DATA, high -> IDLE (glitch reject, no o_Rx_Dv).
REQ-017 Every later sample SHALL occur exactly CLK_CY_PER_BIT cycles after the previous one (mid-bit).
REQ-018 DATA SHALL capture DATA_BITS samples LSB first, then go to PARITY if PARITY_MODE != 0, else STOP.
REQ-019 PARITY SHALL compute the error as XOR(data, parity bit) != 0 for even, and == 0 for odd.
REQ-020 STOP SHALL sample STOP_BITS bits; Frame_Err is set if any stop sample is 0.
REQ-021 On the final stop sample, the cycle after it SHALL update o_Rx_Byte and pulse o_Rx_Dv, o_Parity_Err and o_Frame_Err for exactly 1 cycle.
REQ-022 o_Rx_Byte SHALL hold its value until the next o_Rx_Dv.
REQ-023 After a frame error, the FSM SHALL enter WAIT_HIGH and return to IDLE only on a synchronized high; otherwise it returns to IDLE directly.
REQ-024 A falling edge during STOP is not a new start; the next frame is detected only from IDLE.
REQ-025 The bit counter SHALL be clog2(CLK_CY_PER_BIT) bits wide and reload to 0 on each sample, with no wrap beyond CLK_CY_PER_BIT-1.
REQ-026 o_Parity_Err SHALL be constant 0 when PARITY_MODE = 0.

Reset
REQ-027 While i_rst_n = 0, the block SHALL hold: FSM = IDLE, counters = 0, synchronizer = 1, o_Rx_Byte = 0, o_Rx_Dv = o_Parity_Err = o_Frame_Err = o_Busy = 0.
REQ-028 Reset asserted mid-frame SHALL abort the frame without emitting o_Rx_Dv.
REQ-029 After reset release, reception SHALL resume from IDLE on the next valid start bit.

Verification (10 MHz clock, CLK_CY_PER_BIT = 87, bit period 8700 ns)
REQ-030 Defaults, frame 0/8'h8B/parity 0/stop 1 -> o_Rx_Byte = 8'h8B, o_Rx_Dv high 1 cycle, both error flags 0, o_Busy low after.
REQ-031 Same frame with parity bit 1 -> o_Rx_Byte = 8'h8B, o_Parity_Err = 1 coincident with o_Rx_Dv.
REQ-032 Frame 8'h3C with stop = 0, line held low for 3 more bit periods, then high -> single o_Rx_Dv with o_Frame_Err = 1; no further o_Rx_Dv until the line rises and a new frame (8'hA5) arrives, which is received clean.
REQ-033 Low glitch of 20 cycles on an idle line -> no o_Rx_Dv, o_Busy deasserts after the START sample point.
REQ-034 i_rst_n pulsed low during data bit 4 -> all outputs 0, no o_Rx_Dv; next frame 8'h8B is received correctly.
REQ-035 DATA_BITS = 7, PARITY_MODE = 2, STOP_BITS = 2, frame 7'h55 with parity 1 and second stop bit 0 -> o_Rx_Byte = 7'h55, o_Parity_Err = 0, o_Frame_Err = 1.
